// File: rtl/count_seq_checker.sv
// Sequence monitor for modulo-2^WIDTH count buses: lock, error and wrap flags.
// Define CNT_CHK_DOWN_EN to check down counters (step rule prev-1).
module count_seq_checker #(
  parameter int WIDTH     = 3,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 sample_en,
  output logic                 locked,
  output logic                 err,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_e;

`ifdef CNT_CHK_DOWN_EN
  localparam logic [WIDTH-1:0] WRAP_FROM = '0;
  function automatic logic [WIDTH-1:0] step_f(
    input logic [WIDTH-1:0] v
  );
    return v - WIDTH'(1);
  endfunction
`else
  localparam logic [WIDTH-1:0] WRAP_FROM = '1;
  function automatic logic [WIDTH-1:0] step_f(
    input logic [WIDTH-1:0] v
  );
    return v + WIDTH'(1);
  endfunction
`endif

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic                 pvalid_q, pvalid_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 err_q, err_d;
  logic                 wrap_q, wrap_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     exp_q, exp_d;

  logic                 match;
  logic [RUN_W-1:0]     run_inc;

  assign match   = (q_in == step_f(prev_q));
  assign run_inc = run_q + RUN_W'(1);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    pvalid_d = pvalid_q;
    run_d    = run_q;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    if (sample_en) begin
      prev_d   = q_in;
      pvalid_d = 1'b1;
      exp_d    = step_f(q_in);
      unique case (state_q)
        SEARCH: begin
          // First sample after reset only seeds prev.
          if (pvalid_q) begin
            if (!match) begin
              run_d = '0;
            end else if (run_inc == RUN_LOCK) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_d = (prev_q == WRAP_FROM);
          end else begin
            err_d   = 1'b1;
            state_d = SEARCH;
            run_d   = '0;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      pvalid_q <= 1'b0;
      run_q    <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pvalid_q <= pvalid_d;
      run_q    <= run_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign wrap      = wrap_q;
  assign err_count = cnt_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: spec-level model plus directed literal checks.
// Two instances share stimulus; the second has a 2-bit error counter.
module tb_count_seq_checker;

  localparam int LOCK = 2;
`ifdef CNT_CHK_DOWN_EN
  localparam int DSTEP = 7;
  localparam int WRAPV = 0;
`else
  localparam int DSTEP = 1;
  localparam int WRAPV = 7;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] q_in = '0;
  logic       sample_en = 1'b0;
  logic       locked, err, wrap;
  logic [7:0] err_count;
  logic [2:0] expected;
  logic       locked2, err2, wrap2;
  logic [1:0] err_count2;
  logic [2:0] expected2;

  int pass_cnt = 0;
  int total_cnt = 0;

  int m_have, m_prev, m_locked, m_streak;
  int m_err, m_wrap, m_cnt, m_exp;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(3), .LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .sample_en(sample_en),
    .locked(locked), .err(err), .wrap(wrap),
    .err_count(err_count), .expected(expected)
  );

  count_seq_checker #(.WIDTH(3), .LOCK_CNT(LOCK), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .q_in(q_in), .sample_en(sample_en),
    .locked(locked2), .err(err2), .wrap(wrap2),
    .err_count(err_count2), .expected(expected2)
  );

  task automatic chk(input string nm, input int act, input int want);
    total_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, want);
  endtask

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_locked = 0; m_streak = 0;
    m_err = 0; m_wrap = 0; m_cnt = 0; m_exp = 0;
  endtask

  task automatic model_sample(input int q, input bit en);
    bit legal;
    m_err = 0;
    m_wrap = 0;
    if (!en) return;
    if (m_have != 0) begin
      legal = (((q - m_prev + 8) % 8) == DSTEP);
      if (m_locked != 0) begin
        if (legal) m_wrap = (m_prev == WRAPV);
        else begin
          m_err = 1; m_cnt++; m_locked = 0; m_streak = 0;
        end
      end else if (legal) begin
        m_streak++;
        if (m_streak == LOCK) begin m_locked = 1; m_streak = 0; end
      end else m_streak = 0;
    end
    m_have = 1;
    m_prev = q;
    m_exp = (q + DSTEP) % 8;
  endtask

  always @(negedge clk) begin
    chk("locked", int'(locked), m_locked);
    chk("err", int'(err), m_err);
    chk("wrap", int'(wrap), m_wrap);
    chk("expected", int'(expected), m_exp);
    chk("err_count", int'(err_count), (m_cnt > 255) ? 255 : m_cnt);
    chk("err_count2", int'(err_count2), (m_cnt > 3) ? 3 : m_cnt);
    chk("locked2", int'(locked2), m_locked);
  end

  task automatic apply(input int q, input bit en = 1'b1);
    q_in = 3'(q);
    sample_en = en;
    @(posedge clk);
    #1;
    model_sample(q, en);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    model_reset();
    repeat (n) begin
      q_in = 3'($urandom_range(0, 7));
      sample_en = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    hold_reset(3);
`ifdef CNT_CHK_DOWN_EN
    apply(2); apply(1);
    chk("dn_unlocked", int'(locked), 0);
    apply(0);
    chk("dn_lock", int'(locked), 1);
    chk("dn_exp", int'(expected), 7);
    apply(7);
    chk("dn_wrap", int'(wrap), 1);
    chk("dn_noerr", int'(err), 0);
    apply(6);
    chk("dn_wrap_off", int'(wrap), 0);
    apply(6);
    chk("dn_stall_err", int'(err), 1);
    chk("dn_cnt", int'(err_count), 1);
`else
    apply(0);
    chk("load_only", int'(expected), 1);
    apply(1);
    chk("not_yet", int'(locked), 0);
    apply(2);
    chk("lock_at_2", int'(locked), 1);
    apply(3);
    chk("exp_4", int'(expected), 4);
    chk("no_err", int'(err), 0);
    apply(5);
    chk("err_5", int'(err), 1);
    chk("cnt_1", int'(err_count), 1);
    chk("cnt2_1", int'(err_count2), 1);
    chk("unlock", int'(locked), 0);
    apply(6);
    chk("err_1cyc", int'(err), 0);
    apply(7);
    chk("relock_7", int'(locked), 1);
    apply(0);
    chk("wrap_0", int'(wrap), 1);
    apply(1);
    chk("wrap_1cyc", int'(wrap), 0);
    chk("still_lock", int'(locked), 1);
    apply(1);
    chk("stall_err", int'(err), 1);
    chk("cnt2_2", int'(err_count2), 2);
    apply(5, 1'b0);
    chk("hold_err0", int'(err), 0);
    apply(2, 1'b0); apply(7, 1'b0);
    chk("hold_exp", int'(expected), 2);
    apply(2); apply(3);
    chk("relock_3", int'(locked), 1);
    for (int i = 0; i < 3; i++) begin
      int v;
      v = (m_prev + 3) % 8;
      apply(v);
      chk("cnt2_sat", int'(err_count2), 3);
      chk("cnt8_run", int'(err_count), 3 + i);
      apply((v + 1) % 8);
      apply((v + 3) % 8);
      chk("search_noerr", int'(err), 0);
      apply((v + 4) % 8);
      apply((v + 5) % 8);
      chk("loop_lock", int'(locked), 1);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_lock", int'(locked), 0);
    chk("async_cnt", int'(err_count), 0);
    chk("async_exp", int'(expected), 0);
    model_reset();
    hold_reset(2);
    apply(4);
    chk("post_load", int'(locked), 0);
    chk("post_exp", int'(expected), 5);
    apply(5); apply(6);
    chk("post_lock", int'(locked), 1);
`endif
    apply(0); apply(0); apply(3);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
